inv_subbytes_ctrl: RTL and testbench
====================================

Name: inv_subbytes_ctrl

Overview:
Sequences one shared, variable-latency inverse S-box byte engine across the 16 bytes of a 128-bit AES state, forming the InvSubBytes step of the decryption round.
- Accepts a state word on a valid/ready input port.
- Issues one byte at a time to the engine over a start/done interface and collects each result.
- Presents the reassembled state on a valid/ready output port.
- A watchdog aborts the block if the engine never answers.

Parameters:
NBYTES, 16, bytes per state word (fixed at 16 for AES-128; the index counter is 4 bits).
TIMEOUT, 300, maximum number of WAIT cycles per byte before abort. Must exceed the worst-case engine latency of 255.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input state word valid
in_ready  out  1  block can accept an input state word
in_state  in  128  ciphertext-side state; byte 0 = bits [127:120]
out_valid  out  1  result state word valid
out_ready  in  1  downstream accepts the result
out_state  out  128  InvSubBytes result, same byte ordering as in_state
eng_start  out  1  one-cycle request to the engine
eng_byte  out  8  byte presented to the engine; stable from eng_start until eng_done
eng_done  in  1  one-cycle pulse, engine result valid
eng_result  in  8  engine output byte, sampled when eng_done = 1
busy  out  1  high in every state except IDLE
err_timeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Clock is clk; reset is rst, asynchronous and active-high.
- Reset values:
  - state = IDLE, in_ready = 1 (combinational from IDLE).
  - out_valid = 0, out_state = 0, eng_start = 0, eng_byte = 0.
  - busy = 0, err_timeout = 0.
  - byte index = 0, watchdog = 0, capture register = 0.
- IDLE:
  - in_ready = 1.
  - When in_valid & in_ready: capture in_state, set index = 0, go to ISSUE.
  - eng_done is ignored in IDLE.
- ISSUE (one cycle):
  - eng_start = 1; eng_byte = capture byte[index].
  - Clear the watchdog and go to WAIT.
  - eng_done seen in this cycle is ignored; the engine must not respond earlier than the next cycle.
- WAIT:
  - eng_byte is held.
  - On eng_done, write eng_result into result byte[index].
    - If index == 15, go to OUTPUT.
    - Otherwise increment index and go to ISSUE.
  - Each cycle without eng_done increments the watchdog.
  - If the watchdog reaches TIMEOUT-1 with no eng_done: pulse err_timeout for one cycle, discard the word, go to IDLE. No out_valid is produced for that word.
- OUTPUT:
  - out_valid = 1 and out_state holds the result.
  - Both stay stable until out_valid & out_ready, then go to IDLE.
  - in_ready = 0 throughout OUTPUT, so there is no input/output overlap. Back-to-back words cost one IDLE cycle.
- Latency: with the engine answering L cycles after eng_start (L ≥ 1), out_valid rises 16·(L+1) clock edges after the accepting edge. Minimum is 32.
- Bytes are processed in order 0..15. Result byte i occupies the same bit slice as input byte i.
- Only one engine request is outstanding at any time.
- Reset asserted mid-operation (any state) returns the block to IDLE immediately, asynchronously. The partial word is lost and no err_timeout is raised.
- An eng_done pulse in IDLE or OUTPUT has no effect.

Decomposition:
- Shared package aes_pkg holds:
  - the state-enum typedef {IDLE, ISSUE, WAIT, OUTPUT};
  - AES_STATE_W = 128 and AES_BYTE_W = 8;
  - a byte-slice helper function (byte i = bits [127-8i -: 8]).
- Sub-module sbox_inv_seq: a wrapper that adds start/done handshaking around the existing multi-cycle inverse S-box engine. It is instantiated beside this controller, not inside it, so the bench can substitute a behavioural engine model.

Test Plan:
1. in_state = 128'h63636363…63, model engine L = 1 -> out_state = 128'h0, out_valid exactly 32 edges after accept; the bench checks eng_start pulses 16 times.
2. in_state bytes 0x00,0x7c,0x63,… repeating, engine latency varying randomly from 1 to 255 -> out_state bytes 0x52,0x01,0x00,… in order; eng_byte stable throughout each WAIT.
3. out_ready held low for 10 cycles after out_valid -> out_valid and out_state stable; in_ready = 0; with in_valid held high, the next word is accepted one cycle after the output handshake.
4. Engine withholds eng_done on byte 5 -> err_timeout pulses once, TIMEOUT WAIT cycles after that eng_start; block returns to IDLE; a following word completes correctly.
5. rst asserted during WAIT on byte 9 -> all outputs return to reset values asynchronously; a late eng_done after reset is ignored; the next word completes correctly.
6. Spurious eng_done pulses in IDLE and in the ISSUE cycle -> no state change and no corruption of result bytes.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, controller state encoding and byte-slice helper.
package aes_pkg;
    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W = 8;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} ctrl_state_t;
    // Byte 0 is the most significant byte of the state word.
    function automatic logic [AES_BYTE_W-1:0] aes_byte(input logic [AES_STATE_W-1:0] s, input logic [3:0] i);
        return AES_BYTE_W'(s >> {4'd15 - i, 3'b000});
    endfunction
endpackage

// File: rtl/sbox_inv_seq.sv
// sbox_inv_seq: start/done wrapper around a multi-cycle inverse S-box engine.
// The GF(2^8) inverse is found by trial multiplication, so latency is 1..255 cycles.
module sbox_inv_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic [7:0] result
);
    logic       run, hit;
    logic [7:0] t, cand;
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            p = b[k] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction
    function automatic logic [7:0] inv_affine(input logic [7:0] a);
        return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    endfunction
    always_comb begin
        hit = (t == 8'h00) || (gmul(cand, t) == 8'h01);
        done = run && hit;
        result = (t == 8'h00) ? 8'h00 : cand;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= 1'b0;
            t <= 8'h00;
            cand <= 8'h00;
        end else if (start) begin
            run <= 1'b1;
            t <= inv_affine(data);
            cand <= 8'h01;
        end else if (run) begin
            run <= !hit;
            cand <= cand + 8'h01;
        end
    end
endmodule

// File: rtl/inv_subbytes_ctrl.sv
// inv_subbytes_ctrl: sequences 16 state bytes through a shared start/done
// inverse S-box engine, with a per-byte watchdog that aborts a stalled word.
module inv_subbytes_ctrl import aes_pkg::*; #(
    parameter int NBYTES = 16,
    parameter int TIMEOUT = 300
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   eng_start,
    output logic [AES_BYTE_W-1:0]  eng_byte,
    input  logic                   eng_done,
    input  logic [AES_BYTE_W-1:0]  eng_result,
    output logic                   busy,
    output logic                   err_timeout
);
    localparam int WD_W = $clog2(TIMEOUT);
    ctrl_state_t            state, state_nx;
    logic [AES_STATE_W-1:0] cap, res;
    logic [3:0]             idx;
    logic [WD_W-1:0]        wdog;
    logic [6:0]             sh;
    logic                   last, expire;
    always_comb begin
        last = idx == 4'(NBYTES - 1);
        expire = (state == WAIT) && !eng_done && (wdog == WD_W'(TIMEOUT - 1));
        sh = {4'd15 - idx, 3'b000};
        state_nx = (state == IDLE)  ? (in_valid ? ISSUE : IDLE) :
                   (state == ISSUE) ? WAIT :
                   (state == WAIT)  ? (eng_done ? (last ? OUTPUT : ISSUE) : (expire ? IDLE : WAIT)) :
                   (out_ready ? IDLE : OUTPUT);
        in_ready = state == IDLE;
        busy = state != IDLE;
        eng_start = state == ISSUE;
        eng_byte = aes_byte(cap, idx);
        out_valid = state == OUTPUT;
        out_state = (state == OUTPUT) ? res : '0;
        err_timeout = expire;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cap <= '0;
            res <= '0;
            idx <= 4'd0;
            wdog <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                cap <= in_state;
                idx <= 4'd0;
            end
            if (state == ISSUE)
                wdog <= '0;
            // eng_done only counts while a request is outstanding
            if (state == WAIT && eng_done) begin
                res <= (res & ~(128'hFF << sh)) | ({120'b0, eng_result} << sh);
                idx <= last ? idx : idx + 4'd1;
            end else if (state == WAIT)
                wdog <= wdog + 1'b1;
        end
    end
endmodule

// File: tb/tb_inv_subbytes_ctrl.sv
// tb_inv_subbytes_ctrl: table-driven and hand-sequenced checks of the InvSubBytes
// controller against a behavioural engine and a table-based inverse S-box model.
module tb_inv_subbytes_ctrl;
    localparam int TIMEOUT = 300;
    logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic         eng_start, eng_done, busy, err_timeout;
    logic [127:0] in_state, out_state;
    logic [7:0]   eng_byte, eng_result;
    logic         eng_done_m = 1'b0, spur = 1'b0;
    logic [7:0]   eng_res_m = 8'h00;
    logic [7:0]   inv_t[256];
    int           checks = 0, errors = 0;
    int           lat_lo = 1, lat_hi = 1, withhold = -1, n_starts = 0;
    bit           eng_act = 1'b0, spur_issue = 1'b0;
    typedef struct {
        logic [127:0] din;
        logic [127:0] exp;
        int           lo;
        int           hi;
    } vec_t;
    vec_t vecs[4];

    assign eng_done = eng_done_m | spur;
    assign eng_result = spur ? 8'hAA : eng_res_m;

    inv_subbytes_ctrl #(.NBYTES(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .eng_start(eng_start), .eng_byte(eng_byte), .eng_done(eng_done), .eng_result(eng_result),
        .busy(busy), .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish, got running required done");
        $fatal(1);
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 0;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // Forward S-box from its definition (GF inverse + affine), then inverted as a table.
    task automatic build_tables();
        logic [7:0] y, s;
        for (int x = 0; x < 256; x++) begin
            y = 0;
            for (int c = 1; c < 256; c++) if (x != 0 && gm(8'(x), 8'(c)) == 8'h01) y = 8'(c);
            s = y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
            inv_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_t[s[127-8*i -: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Behavioural engine: answers a random 1..N cycles after eng_start, optionally never.
    initial begin : engine
        logic [7:0] eb;
        int el;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                eb = eng_byte;
                el = $urandom_range(lat_hi, lat_lo);
                n_starts++;
                if (n_starts - 1 != withhold) begin
                    eng_act = 1'b1;
                    for (int k = 1; k <= el; k++) begin
                        @(posedge clk);
                        #1;
                        if (busy) chk("eng_byte_stable", eng_byte, eb);
                    end
                    eng_done_m = 1'b1;
                    eng_res_m = inv_t[eb];
                    @(posedge clk);
                    #1 eng_done_m = 1'b0;
                    eng_act = 1'b0;
                end
            end
        end
    end

    initial begin : spurious
        forever begin
            @(negedge clk);
            if (spur_issue && eng_start) begin
                spur = 1'b1;
                @(posedge clk);
                #1 spur = 1'b0;
            end
        end
    end

    task automatic idle_chk(input string nm);
        chk({nm, "_flags"}, {in_ready, busy, out_valid, eng_start, err_timeout}, 5'b10000);
        chk({nm, "_out_state"}, out_state, 128'h0);
        chk({nm, "_eng_byte"}, eng_byte, 8'h00);
    endtask

    task automatic send_word(input logic [127:0] s);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("accept_ready", in_ready, 1);
        in_state = s;
        in_valid = 1'b1;
        n_starts = 0;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int e);
        e = 0;
        do begin
            @(posedge clk);
            #1 e++;
        end while (!out_valid && e < 5000);
        chk("out_valid_seen", out_valid, 1);
    endtask

    task automatic hs();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("handshake_flags", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic run_word(input logic [127:0] s, input logic [127:0] exp, input int lat);
        int e;
        send_word(s);
        wait_out(e);
        if (lat > 0) chk("latency", e, lat);
        chk("out_state", out_state, exp);
        chk("in_ready_in_output", in_ready, 0);
        chk("eng_starts", n_starts, 16);
        hs();
    endtask

    task automatic count_starts(input int n);
        int cnt, g;
        cnt = 0;
        g = 0;
        while (cnt < n && g < 5000) begin
            @(negedge clk);
            g++;
            if (eng_start) cnt++;
        end
        chk("start_count", cnt, n);
    endtask

    initial begin : main
        logic [127:0] p, e, v, w;
        int k;
        build_tables();
        for (int i = 0; i < 16; i++) begin
            p[127-8*i -: 8] = (i % 3 == 0) ? 8'h00 : (i % 3 == 1) ? 8'h7c : 8'h63;
            e[127-8*i -: 8] = (i % 3 == 0) ? 8'h52 : (i % 3 == 1) ? 8'h01 : 8'h00;
        end
        vecs[0] = '{{16{8'h63}}, 128'h0, 1, 1};
        vecs[1] = '{p, e, 1, 255};
        v = {$urandom, $urandom, $urandom, $urandom};
        vecs[2] = '{v, model(v), 2, 2};
        v = {$urandom, $urandom, $urandom, $urandom};
        vecs[3] = '{v, model(v), 1, 7};

        rst = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #1 idle_chk("reset");
        @(negedge clk) rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            lat_lo = vecs[i].lo;
            lat_hi = vecs[i].hi;
            run_word(vecs[i].din, vecs[i].exp, vecs[i].lo == vecs[i].hi ? 16 * (vecs[i].lo + 1) : 0);
        end

        // Output back-pressure, then back-to-back acceptance one cycle after handshake.
        lat_lo = 1; lat_hi = 3;
        v = {$urandom, $urandom, $urandom, $urandom};
        w = {$urandom, $urandom, $urandom, $urandom};
        send_word(v);
        wait_out(k);
        chk("bp_state", out_state, model(v));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_state", out_state, model(v));
            chk("bp_hold_flags", {out_valid, in_ready}, 2'b10);
        end
        in_state = w;
        in_valid = 1'b1;
        hs();
        n_starts = 0;
        chk("b2b_idle", {busy, in_ready}, 2'b01);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_issue", {eng_start, busy}, 2'b11);
        wait_out(k);
        chk("b2b_state", out_state, model(w));
        hs();

        // Engine never answers byte 5.
        lat_lo = 1; lat_hi = 4; withhold = 5;
        send_word({$urandom, $urandom, $urandom, $urandom});
        count_starts(6);
        k = 0;
        do begin
            @(posedge clk);
            #1 k++;
        end while (!err_timeout && k < 1000);
        chk("timeout_cycles", k, TIMEOUT);
        @(posedge clk);
        #1 chk("timeout_after", {err_timeout, in_ready, busy, out_valid}, 4'b0100);
        withhold = -1;
        v = {$urandom, $urandom, $urandom, $urandom};
        run_word(v, model(v), 0);

        // Asynchronous reset while waiting on byte 9; the engine answers late.
        lat_lo = 20; lat_hi = 20;
        send_word({$urandom, $urandom, $urandom, $urandom});
        count_starts(10);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 idle_chk("mid_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        k = 0;
        while (eng_act && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        #1 chk("late_done_ignored", {busy, in_ready, out_valid}, 3'b010);
        lat_lo = 1; lat_hi = 5;
        v = {$urandom, $urandom, $urandom, $urandom};
        run_word(v, model(v), 0);

        // Spurious eng_done in IDLE and in every ISSUE cycle.
        lat_lo = 1; lat_hi = 1;
        @(posedge clk);
        #1 spur = 1'b1;
        @(posedge clk);
        #1 spur = 1'b0;
        chk("spur_idle", {busy, in_ready}, 2'b01);
        spur_issue = 1'b1;
        v = {$urandom, $urandom, $urandom, $urandom};
        run_word(v, model(v), 32);
        spur_issue = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
